// File: rtl/dcache_write_buffer_pkg.sv
// Shared types for the data-cache write buffer: line/address widths,
// the entry record and the drain FSM state encoding.
package proc_pkg;

  localparam int LINE_W           = 256;
  localparam int ADDR_W           = 16;
  localparam int LINE_OFFSET_BITS = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Bus bundle between the cache stage, the write buffer and the arbiter
// data port. The master side is the cache stage plus memory; the slave
// side is the write buffer itself.
interface dcache_write_buffer_if #(
  parameter int cache_line_width = proc_pkg::LINE_W,
  parameter int addr_width       = proc_pkg::ADDR_W,
  parameter int depth            = 4
);
  localparam int CNT_W = $clog2(depth) + 1;

  logic                        push_valid;
  logic [addr_width-1:0]       push_addr;
  logic [cache_line_width-1:0] push_data;
  logic                        push_ready;

  logic [addr_width-1:0]       lookup_addr;
  logic                        lookup_hit;
  logic [cache_line_width-1:0] lookup_data;

  logic                        petitionDat;
  logic [addr_width-1:0]       addrDat;
  logic [cache_line_width-1:0] dataWrittenToMem;
  logic                        weDat;
  logic                        serviceReadyDat;

  logic                        empty;
  logic [CNT_W-1:0]            count;

  modport master (
    output push_valid, push_addr, push_data, lookup_addr, serviceReadyDat,
    input  push_ready, lookup_hit, lookup_data, petitionDat, addrDat,
           dataWrittenToMem, weDat, empty, count
  );

  modport slave (
    input  push_valid, push_addr, push_data, lookup_addr, serviceReadyDat,
    output push_ready, lookup_hit, lookup_data, petitionDat, addrDat,
           dataWrittenToMem, weDat, empty, count
  );

endinterface

// File: rtl/dcache_write_buffer_match.sv
// Tag compare across all buffer entries with youngest-first priority.
// "Youngest" means the valid match closest behind the write pointer.
// Entries flagged in i_exclude are never reported as a match.
module wb_match_unit #(
  parameter int depth = 4,
  parameter int tag_w = 11,
  parameter int ptr_w = $clog2(depth)
) (
  input  logic [depth-1:0]            i_valid,
  input  logic [depth-1:0][tag_w-1:0] i_tags,
  input  logic [ptr_w-1:0]            i_wrPtr,
  input  logic [tag_w-1:0]            i_lookupTag,
  input  logic [depth-1:0]            i_exclude,
  output logic                        o_hit,
  output logic [ptr_w-1:0]            o_idx
);

  logic [ptr_w-1:0] w_idx;

  // Walk from oldest to youngest so the last match written wins.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_idx = '0;
    for (int k = depth; k >= 1; k--) begin
      w_idx = i_wrPtr - ptr_w'(k);
      if (i_valid[w_idx] && !i_exclude[w_idx] && (i_tags[w_idx] == i_lookupTag)) begin
        o_hit = 1'b1;
        o_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the data-cache stage and the arbiter data port.
// Evicted dirty lines are queued in a circular FIFO and drained in push
// order over petitionDat/serviceReadyDat; load misses can be served from
// pending entries through the lookup port.
// Optional feature macro: WB_COALESCE_EN (merge a push into a matching
// non-head entry instead of allocating).
module dcache_write_buffer
  import proc_pkg::*;
#(
  parameter int cache_line_width = LINE_W,
  parameter int addr_width       = ADDR_W,
  parameter int depth            = 4,
  parameter int line_offset_bits = LINE_OFFSET_BITS
) (
  input logic                clk,
  input logic                reset,
  dcache_write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = addr_width - line_offset_bits;

  // Only the line tag is stored; the byte offset is always zero on the way out.
  logic [depth-1:0]                       r_valid;
  logic [depth-1:0][TAG_W-1:0]            r_tag;
  logic [depth-1:0][cache_line_width-1:0] r_data;
  logic [PTR_W-1:0]                       r_wrPtr;
  logic [PTR_W-1:0]                       r_rdPtr;
  logic [CNT_W-1:0]                       r_count;
  wb_state_t                              r_state;
  wb_state_t                              w_nextState;

  logic             w_full;
  logic             w_empty;
  logic             w_retire;
  logic             w_alloc;
  logic             w_coalesce;
  logic             w_petition;
  logic             w_lookupHit;
  logic [PTR_W-1:0] w_lookupIdx;
  logic [TAG_W-1:0] w_pushTag;
  logic [TAG_W-1:0] w_lookupTag;
  logic             w_unusedOffsets;

  assign w_pushTag   = bus.push_addr[addr_width-1:line_offset_bits];
  assign w_lookupTag = bus.lookup_addr[addr_width-1:line_offset_bits];
  assign w_unusedOffsets = ^{bus.push_addr[line_offset_bits-1:0],
                             bus.lookup_addr[line_offset_bits-1:0]};

  assign w_full   = (r_count == CNT_W'(depth));
  assign w_empty  = (r_count == '0);
  assign w_retire = (r_state == WB_REQ) && bus.serviceReadyDat;

  wb_match_unit #(
    .depth (depth),
    .tag_w (TAG_W)
  ) u_lookupMatch (
    .i_valid     (r_valid),
    .i_tags      (r_tag),
    .i_wrPtr     (r_wrPtr),
    .i_lookupTag (w_lookupTag),
    .i_exclude   ('0),
    .o_hit       (w_lookupHit),
    .o_idx       (w_lookupIdx)
  );

`ifdef WB_COALESCE_EN
  logic [depth-1:0] w_coExclude;
  logic             w_coHit;
  logic [PTR_W-1:0] w_coIdx;

  // The head under petition must stay stable, so it never absorbs a push.
  always_comb begin
    w_coExclude = '0;
    if (r_state == WB_REQ) w_coExclude[r_rdPtr] = 1'b1;
  end

  wb_match_unit #(
    .depth (depth),
    .tag_w (TAG_W)
  ) u_coMatch (
    .i_valid     (r_valid),
    .i_tags      (r_tag),
    .i_wrPtr     (r_wrPtr),
    .i_lookupTag (w_pushTag),
    .i_exclude   (w_coExclude),
    .o_hit       (w_coHit),
    .o_idx       (w_coIdx)
  );

  assign w_coalesce = bus.push_valid && w_coHit;
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_alloc = bus.push_valid && !w_full && !w_coalesce;

  // FIFO storage, pointers and occupancy; retire and allocate may share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_retire) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_tag[r_wrPtr]   <= w_pushTag;
        r_data[r_wrPtr]  <= bus.push_data;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
`ifdef WB_COALESCE_EN
      if (w_coalesce) r_data[w_coIdx] <= bus.push_data;
`endif
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_retire);
    end
  end

  // Drain FSM state register; reset drops the petition immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= WB_IDLE;
    else       r_state <= w_nextState;
  end

  // Request whenever work is pending; always pass through IDLE after a retire.
  always_comb begin
    w_nextState = r_state;
    w_petition  = 1'b0;
    case (r_state)
      WB_IDLE: if (!w_empty) w_nextState = WB_REQ;
      WB_REQ: begin
        w_petition = 1'b1;
        if (bus.serviceReadyDat) w_nextState = WB_IDLE;
      end
      default: w_nextState = WB_IDLE;
    endcase
  end

  assign bus.push_ready       = !w_full;
  assign bus.petitionDat      = w_petition;
  assign bus.weDat            = w_petition;
  assign bus.addrDat          = w_empty ? '0 : {r_tag[r_rdPtr], {line_offset_bits{1'b0}}};
  assign bus.dataWrittenToMem = w_empty ? '0 : r_data[r_rdPtr];
  assign bus.lookup_hit       = w_lookupHit;
  assign bus.lookup_data      = w_lookupHit ? r_data[w_lookupIdx] : '0;
  assign bus.empty            = w_empty;
  assign bus.count            = r_count;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer. Expected memory writes are
// queued when lines are pushed and compared as the buffer presents them.
module tb_dcache_write_buffer;
  import proc_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wb_entry_t sbQ[$];

  dcache_write_buffer_if #(
    .cache_line_width (LINE_W),
    .addr_width       (ADDR_W),
    .depth            (4)
  ) bus ();

  dcache_write_buffer #(
    .cache_line_width (LINE_W),
    .addr_width       (ADDR_W),
    .depth            (4),
    .line_offset_bits (LINE_OFFSET_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] mkData(input logic [31:0] seed);
    logic [LINE_W-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = seed ^ (32'h9E37_79B9 * 32'(i + 1));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doPush(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data);
    int waited;
    wb_entry_t e;
    waited = 0;
    bus.push_valid = 1'b1;
    bus.push_addr  = addr;
    bus.push_data  = data;
    #1;
    while (bus.push_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.push_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL push_timeout: push_ready=%b expected 1", bus.push_ready);
    end
    tick();
    bus.push_valid = 1'b0;
    e.valid = 1'b1;
    e.addr  = {addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    e.data  = data;
    sbQ.push_back(e);
  endtask

  task automatic serviceHead(input int holdCycles);
    int waited;
    wb_entry_t exp;
    waited = 0;
    while (bus.petitionDat !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.petitionDat !== 1'b1) begin
      failures++;
      $display("[TB] FAIL petition_timeout: petitionDat=%b expected 1", bus.petitionDat);
      return;
    end
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_write: addrDat=%h with no pending write expected", bus.addrDat);
      return;
    end
    exp = sbQ.pop_front();
    checks++;
    if (bus.addrDat !== exp.addr) begin
      failures++;
      $display("[TB] FAIL drain_addr: got %h expected %h", bus.addrDat, exp.addr);
    end
    checks++;
    if (bus.dataWrittenToMem !== exp.data) begin
      failures++;
      $display("[TB] FAIL drain_data: addr %h got %h expected %h", exp.addr, bus.dataWrittenToMem, exp.data);
    end
    checks++;
    if (bus.weDat !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_we: weDat=%b expected 1", bus.weDat);
    end
    repeat (holdCycles) tick();
    checks++;
    if (bus.addrDat !== exp.addr || bus.petitionDat !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_hold: addr %h pet %b expected %h pet 1", bus.addrDat, bus.petitionDat, exp.addr);
    end
    bus.serviceReadyDat = 1'b1;
    tick();
    bus.serviceReadyDat = 1'b0;
    checks++;
    if (bus.petitionDat !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_gap: petitionDat=%b expected 0 after retire", bus.petitionDat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.count !== 3'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d expected 0", bus.count); end
    checks++;
    if (bus.empty !== 1'b1) begin failures++; $display("[TB] FAIL rst_empty: got %b expected 1", bus.empty); end
    checks++;
    if (bus.push_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_push_ready: got %b expected 1", bus.push_ready); end
    checks++;
    if (bus.petitionDat !== 1'b0 || bus.weDat !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_petition: pet %b we %b expected 0 0", bus.petitionDat, bus.weDat);
    end
    checks++;
    if (bus.lookup_hit !== 1'b0) begin failures++; $display("[TB] FAIL rst_lookup: got %b expected 0", bus.lookup_hit); end
    checks++;
    if (bus.addrDat !== '0 || bus.dataWrittenToMem !== '0) begin
      failures++;
      $display("[TB] FAIL rst_head: addr %h data %h expected zero", bus.addrDat, bus.dataWrittenToMem);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_push();
    doPush(16'h1240, mkData(32'hA));
    checks++;
    if (bus.count !== 3'd1 || bus.petitionDat !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_accept: count %0d pet %b expected 1 0", bus.count, bus.petitionDat);
    end
    tick();
    checks++;
    if (bus.petitionDat !== 1'b1 || bus.addrDat !== 16'h1240) begin
      failures++;
      $display("[TB] FAIL single_petition: pet %b addr %h expected 1 1240", bus.petitionDat, bus.addrDat);
    end
    serviceHead(3);
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_empty: empty %b count %0d expected 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_full();
    wb_entry_t e;
    for (int i = 0; i < 4; i++) doPush(16'(16'h5000 + i * 16'h0020), mkData(32'(50 + i)));
    checks++;
    if (bus.count !== 3'd4 || bus.push_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_state: count %0d ready %b expected 4 0", bus.count, bus.push_ready);
    end
    bus.push_valid = 1'b1;
    bus.push_addr  = 16'h5080;
    bus.push_data  = mkData(32'd54);
    tick();
    tick();
    checks++;
    if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL full_hold: count %0d expected 4", bus.count); end
    serviceHead(0);
    checks++;
    if (bus.count !== 3'd3 || bus.push_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_retire: count %0d ready %b expected 3 1", bus.count, bus.push_ready);
    end
    tick();
    bus.push_valid = 1'b0;
    checks++;
    if (bus.count !== 3'd4) begin failures++; $display("[TB] FAIL full_late_accept: count %0d expected 4", bus.count); end
    e.valid = 1'b1;
    e.addr  = 16'h5080;
    e.data  = mkData(32'd54);
    sbQ.push_back(e);
    for (int i = 0; i < 4; i++) serviceHead(1);
  endtask

  task automatic test_lookup();
    doPush(16'h2000, mkData(32'hC));
    doPush(16'h3000, mkData(32'hD));
    bus.lookup_addr = 16'h3010;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== mkData(32'hD)) begin
      failures++;
      $display("[TB] FAIL lookup_3000: hit %b data %h expected 1 %h", bus.lookup_hit, bus.lookup_data, mkData(32'hD));
    end
    bus.lookup_addr = 16'h201F;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== mkData(32'hC)) begin
      failures++;
      $display("[TB] FAIL lookup_head: hit %b data %h expected 1 %h", bus.lookup_hit, bus.lookup_data, mkData(32'hC));
    end
    bus.lookup_addr = 16'h4000;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b0) begin failures++; $display("[TB] FAIL lookup_miss: hit %b expected 0", bus.lookup_hit); end
    serviceHead(0);
    serviceHead(0);
  endtask

  task automatic test_duplicate();
    logic [2:0] expCount;
    doPush(16'h2000, mkData(32'hAAAA));
    doPush(16'h2000, mkData(32'hBBBB));
`ifdef WB_COALESCE_EN
    void'(sbQ.pop_back());
    sbQ[sbQ.size()-1].data = mkData(32'hBBBB);
    expCount = 3'd1;
`else
    expCount = 3'd2;
`endif
    bus.lookup_addr = 16'h2000;
    #1;
    checks++;
    if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== mkData(32'hBBBB)) begin
      failures++;
      $display("[TB] FAIL dup_youngest: hit %b data %h expected 1 %h", bus.lookup_hit, bus.lookup_data, mkData(32'hBBBB));
    end
    checks++;
    if (bus.count !== expCount) begin failures++; $display("[TB] FAIL dup_count: got %0d expected %0d", bus.count, expCount); end
    for (int i = 0; i < 4 && sbQ.size() > 0; i++) serviceHead(0);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) doPush(16'(16'h7000 + i * 16'h0020), mkData(32'(70 + i)));
    checks++;
    if (bus.petitionDat !== 1'b1 || bus.count !== 3'd3) begin
      failures++;
      $display("[TB] FAIL midrst_setup: pet %b count %0d expected 1 3", bus.petitionDat, bus.count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.petitionDat !== 1'b0 || bus.weDat !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_petition: pet %b we %b expected 0 0", bus.petitionDat, bus.weDat);
    end
    tick();
    checks++;
    if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_cleared: count %0d empty %b expected 0 1", bus.count, bus.empty);
    end
    reset = 1'b0;
    sbQ.delete();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      doPush(16'(16'h8000 + i * 16'h0040), mkData(32'(100 + i)));
      if (sbQ.size() >= 3) serviceHead(i % 3);
    end
    for (int i = 0; i < 10 && sbQ.size() > 0; i++) serviceHead(0);
    checks++;
    if (bus.empty !== 1'b1 || sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL wrap_drained: empty %b pending %0d expected 1 0", bus.empty, sbQ.size());
    end
  endtask

  initial begin
    checks              = 0;
    failures            = 0;
    reset               = 1'b1;
    bus.push_valid      = 1'b0;
    bus.push_addr       = '0;
    bus.push_data       = '0;
    bus.lookup_addr     = '0;
    bus.serviceReadyDat = 1'b0;
    test_reset();
    test_single_push();
    test_full();
    test_lookup();
    test_duplicate();
    test_reset_mid_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Sits between the data-cache stage and the memory arbiter's data port.
- Queues evicted dirty cache lines as address plus full-line data, so a load miss does not wait for the write-back.
- Drains entries to memory in order over the petition/serviceReady handshake.
- Forwards buffered line data to the cache stage when a miss hits a pending entry.

Parameters:
- cache_line_width, 256, bits per line (entry data width)
- addr_width, 16, byte address width
- depth, 4, number of entries (power of two, at least 2)
- line_offset_bits, 5, low address bits ignored in compares (log2 of bytes per line)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- push_valid  in  1  cache stage presents an evicted line
- push_addr  in  addr_width  line address of the evicted line
- push_data  in  cache_line_width  evicted line data
- push_ready  out  1  buffer can accept a push this cycle
- lookup_addr  in  addr_width  miss address from the cache stage
- lookup_hit  out  1  a pending entry matches lookup_addr
- lookup_data  out  cache_line_width  data of the youngest matching entry
- petitionDat  out  1  write request to the arbiter
- addrDat  out  addr_width  head entry address, low offset bits forced to 0
- dataWrittenToMem  out  cache_line_width  head entry data
- weDat  out  1  write enable, equal to petitionDat
- serviceReadyDat  in  1  single-cycle pulse: memory has completed the write
- empty  out  1  no entries pending
- count  out  $clog2(depth)+1  number of valid entries

Behaviour:
- Reset values: all entries invalid; pointers at 0; count=0; empty=1; push_ready=1; petitionDat=0; weDat=0; lookup_hit=0. addrDat and dataWrittenToMem are 0 while the buffer is empty.
- Storage: circular FIFO with wr_ptr, rd_ptr and count. Pointers wrap modulo depth.
- Push rule:
  - push_ready = (count != depth).
  - A push is accepted when push_valid && push_ready.
  - The entry is written at wr_ptr on that clock edge and is visible to lookup on the next cycle.
  - push_valid while full is ignored; the cache stage must hold it.
- Drain FSM has two states:
  - IDLE: petitionDat=0. Go to REQ when count != 0.
  - REQ: petitionDat=1. addrDat and data come from the rd_ptr entry and stay stable until serviceReadyDat.
  - On serviceReadyDat in REQ: retire the head (rd_ptr+1, count-1). Go to IDLE next cycle, so there is always at least one idle cycle between petitions.
  - serviceReadyDat in IDLE is ignored.
- Latency: the first petition is asserted 1 cycle after the first push is accepted.
- Simultaneous push and retire: count is unchanged and both pointers advance. push_ready is computed from the registered count only, so a full buffer does not accept a push in the same cycle it retires.
- Lookup (combinational):
  - Compare addr[addr_width-1:line_offset_bits] against every valid entry.
  - On several matches, return the youngest (closest behind wr_ptr).
  - The head entry under petition still matches until it is retired.
- Reset mid-drain: the FSM returns to IDLE asynchronously and petitionDat deasserts immediately. Pending entries are lost; this is acceptable because reset also clears the cache.
- Ordering: writes leave strictly in push order. No entry is ever dropped except by reset.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - A push whose line address matches a valid entry that is not the head in REQ overwrites that entry's data in place.
  - Pointers and count are unchanged, and push_ready is ignored for a coalescing push (it is accepted even when full).
  - A match against the head in REQ allocates a new entry as normal.
- Undefined: every accepted push allocates a new entry. Duplicate addresses may coexist and lookup returns the youngest.

Decomposition:
- Shared package proc_pkg:
  - LINE_W=256, ADDR_W=16, LINE_OFFSET_BITS=5
  - typedef wb_entry_t {valid, addr, data}
  - enum wb_state_t {WB_IDLE, WB_REQ}
- One sub-module, wb_match_unit: combinational compare across the entries plus youngest-match priority select. It is shared with the coalescing path.

Test Plan:
- Reset, then push addr 0x1240 with data pattern A:
  - petitionDat=1 on the next cycle with addrDat=0x1240.
  - serviceReadyDat after 3 cycles gives empty=1 and petitionDat=0 one cycle later.
- Push 4 lines without serviceReadyDat:
  - count=4 and push_ready=0.
  - A fifth push is held and not accepted.
  - One serviceReadyDat accepts it the cycle after count drops to 3.
- Push 0x2000 then 0x3000, lookup 0x3010:
  - lookup_hit=1 with the 0x3000 data.
  - Lookup 0x4000 gives lookup_hit=0.
- Push 0x2000 (A) then 0x2000 (B), lookup 0x2000:
  - Returns B.
  - With WB_COALESCE_EN and the first entry not the head in REQ, count stays 1.
- Assert reset while petitionDat=1 with 3 entries pending:
  - petitionDat=0 immediately, then count=0 and empty=1.
- Wrap-around: push and drain 10 lines in sequence:
  - Memory receives all 10 addresses in push order with matching data.
